// File: rtl/uart_rx_mmio_if.sv
// Memory-mapped read port shared by the core data bus and the UART receiver.
// The core drives address and read strobe; the peripheral returns data and hit.
interface uart_rx_mmio_if;
   logic [15:0] mmio_addr;
   logic        mmio_read;
   logic [7:0]  mmio_rdata;
   logic        mmio_hit;

   modport master (
      output mmio_addr,
      output mmio_read,
      input  mmio_rdata,
      input  mmio_hit
   );

   modport slave (
      input  mmio_addr,
      input  mmio_read,
      output mmio_rdata,
      output mmio_hit
   );
endinterface

// File: rtl/uart_rx_mmio.sv
// MMIO UART receiver: 8N1 deframer into a byte FIFO with status/irq.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity-error flag.
module uart_rx_mmio #(
   parameter int          CLK_FREQ    = 27_000_000,
   parameter int          BAUD        = 115200,
   parameter logic [15:0] ADDR_DATA   = 16'hFF10,
   parameter logic [15:0] ADDR_STATUS = 16'hFF11,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          rx,
   uart_rx_mmio_if.slave bus,
   output logic          rx_irq
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic          rx_m_q, rx_s_q;
   logic [1:0]    flush_q;
   logic          armed_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shr_q, shr_d;
   logic          push, ferr_set, perr_set;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          empty, full, pop, do_push, ovr_set;
   logic          hit_data, hit_stat, rd_data, rd_stat;
   logic          ovr_q, ferr_q, perr_q;
   logic          irq_q;

   // flush_q marks when rx_s_q holds a real line sample rather than its reset value
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_m_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         flush_q <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         rx_m_q  <= rx;
         rx_s_q  <= rx_m_q;
         flush_q <= {flush_q[0], 1'b1};
         if (flush_q[1] && rx_s_q) armed_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shr_q   <= shr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shr_d    = shr_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q && armed_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CPB_M1) begin
               cnt_d = '0;
               shr_d = {rx_s_q, shr_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CPB_M1) begin
               cnt_d    = '0;
               perr_set = ^{shr_q, rx_s_q};
               state_d  = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CPB_M1) begin
               cnt_d    = '0;
               state_d  = S_IDLE;
               push     = rx_s_q;
               ferr_set = !rx_s_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hit_data = bus.mmio_addr == ADDR_DATA;
   assign hit_stat = bus.mmio_addr == ADDR_STATUS;
   assign rd_data  = bus.mmio_read && hit_data;
   assign rd_stat  = bus.mmio_read && hit_stat;
   assign empty    = count_q == '0;
   assign full     = count_q == DEPTH_C;
   assign pop      = rd_data && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push  = push && (!full || pop);
   assign ovr_set  = push && full && !pop;

   always_comb begin
      case ({do_push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q] <= shr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         ovr_q   <= (ovr_q  && !rd_stat) || ovr_set;
         ferr_q  <= (ferr_q && !rd_stat) || ferr_set;
         perr_q  <= (perr_q && !rd_stat) || perr_set;
         irq_q   <= !empty;
      end
   end

   always_comb begin
      bus.mmio_rdata = 8'h00;
      if (hit_data) begin
         bus.mmio_rdata = empty ? 8'h00 : mem_q[rptr_q];
      end else if (hit_stat) begin
         bus.mmio_rdata = {3'b000, perr_q, ferr_q, ovr_q, full, !empty};
      end
   end

   assign bus.mmio_hit = hit_data || hit_stat;
   assign rx_irq       = irq_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: frame table, corner sequences,
// and random frames checked against a queue-based receiver model.
module tb_uart_rx_mmio;
   localparam int CLK_FREQ = 1600;
   localparam int BAUD     = 100;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;
   localparam int DEPTH    = 8;
   localparam logic [15:0] A_DATA = 16'hFF10;
   localparam logic [15:0] A_STAT = 16'hFF11;
`ifdef UART_RX_PARITY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   // 2 sync flops + 1 idle detect, half bit, then 8 data (+parity) + stop
   localparam int PUSH_EDGE = 3 + HALF + (9 + int'(PEN)) * CPB;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;
   logic rx_irq;

   uart_rx_mmio_if bus ();

   uart_rx_mmio #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .ADDR_DATA  (A_DATA),
      .ADDR_STATUS(A_STAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .bus   (bus),
      .rx_irq(rx_irq)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mq[$];
   bit m_ovr, m_ferr, m_perr;

   typedef struct {
      logic [7:0] d;
      bit         stop;
      logic [7:0] exp_stat;
      logic [7:0] exp_data;
      logic [7:0] exp_stat2;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
      @(negedge clock);
      bus.mmio_addr = a;
      bus.mmio_read = 1'b1;
      #1 d = bus.mmio_rdata;
      @(posedge clock);
      #1;
      bus.mmio_read = 1'b0;
      bus.mmio_addr = 16'h0000;
   endtask

   function automatic logic [7:0] m_status();
      return {3'b000, m_perr, m_ferr, m_ovr,
              mq.size() == DEPTH, mq.size() != 0};
   endfunction

   task automatic rd_stat_chk(input string name);
      logic [7:0] d, e;
      e = m_status();
      bus_rd(A_STAT, d);
      check(name, d, e);
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
   endtask

   task automatic rd_data_chk(input string name);
      logic [7:0] d, e;
      e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
      bus_rd(A_DATA, d);
      check(name, d, e);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop,
                             input bit pbad);
      @(posedge clock);
      #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clock);
         #1 rx = d[i];
      end
      if (PEN) begin
         repeat (CPB) @(posedge clock);
         #1 rx = (^d) ^ pbad;
      end
      repeat (CPB) @(posedge clock);
      #1 rx = stop;
      repeat (CPB) @(posedge clock);
      #1 rx = 1'b1;
      repeat (CPB) @(posedge clock);
   endtask

   function automatic void model_frame(input logic [7:0] d, input bit stop,
                                       input bit pbad);
      if (PEN && pbad) m_perr = 1'b1;
      if (!stop) m_ferr = 1'b1;
      else if (mq.size() == DEPTH) m_ovr = 1'b1;
      else mq.push_back(d);
   endfunction

   task automatic frame(input logic [7:0] d, input bit stop, input bit pbad);
      send_frame(d, stop, pbad);
      model_frame(d, stop, pbad);
   endtask

   task automatic do_reset(input logic rx_level);
      rx = rx_level;
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
   endtask

   // pop lands on the exact edge that pushes the newest frame
   task automatic push_pop_same_edge(input int prefill, input logic [7:0] nb);
      logic [7:0] d, e;
      for (int i = 0; i < prefill; i++) frame(8'h30 + 8'(i), 1'b1, 1'b0);
      e = mq.pop_front();
      fork
         send_frame(nb, 1'b1, 1'b0);
         begin
            @(posedge clock);
            repeat (PUSH_EDGE - 1) @(posedge clock);
            bus_rd(A_DATA, d);
         end
      join
      mq.push_back(nb);
      check("pushpop_head", d, e);
      rd_stat_chk("pushpop_status");
      while (mq.size() != 0) rd_data_chk("pushpop_drain");
      rd_data_chk("pushpop_empty");
      rd_stat_chk("pushpop_status_end");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      int cyc;
      int nr;
      bit st, pb;

      tbl[0] = '{8'h5A, 1'b1, 8'h01, 8'h5A, 8'h00};
      tbl[1] = '{8'h3C, 1'b0, 8'h08, 8'h00, 8'h00};
      tbl[2] = '{8'hFF, 1'b1, 8'h01, 8'hFF, 8'h00};
      tbl[3] = '{8'h00, 1'b1, 8'h01, 8'h00, 8'h00};
      tbl[4] = '{8'h81, 1'b1, 8'h01, 8'h81, 8'h00};

      bus.mmio_addr = 16'h0000;
      bus.mmio_read = 1'b0;
      do_reset(1'b1);
      repeat (4) @(posedge clock);

      // reset state and address decode
      #1 check("reset_irq", {7'b0, rx_irq}, 8'h00);
      @(negedge clock);
      bus.mmio_addr = 16'h1234;
      #1 check("nohit_hit", {7'b0, bus.mmio_hit}, 8'h00);
      check("nohit_rdata", bus.mmio_rdata, 8'h00);
      bus.mmio_addr = A_DATA;
      #1 check("hit_data", {7'b0, bus.mmio_hit}, 8'h01);
      bus.mmio_addr = A_STAT;
      #1 check("hit_stat", {7'b0, bus.mmio_hit}, 8'h01);
      rd_stat_chk("reset_status");
      rd_data_chk("reset_data");

      // irq latency for 0xA5
      cyc = 0;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            @(posedge clock);
            #1;
            while (!rx_irq && cyc < 20 * CPB) begin
               @(posedge clock);
               #1 cyc++;
            end
         end
      join
      model_frame(8'hA5, 1'b1, 1'b0);
      n_cmp++;
      if (cyc < (19 * CPB) / 2 + int'(PEN) * CPB ||
          cyc > (19 * CPB) / 2 + int'(PEN) * CPB + 6) begin
         n_bad++;
         $display("FAIL irq_latency: got %0d cycles expected about %0d",
                  cyc, (19 * CPB) / 2 + int'(PEN) * CPB + 3);
      end
      rd_stat_chk("a5_status");
      rd_data_chk("a5_data");
      @(posedge clock);
      #1 check("a5_irq_low", {7'b0, rx_irq}, 8'h00);
      rd_stat_chk("a5_status2");

      // table of single frames
      for (int i = 0; i < 5; i++) begin
         send_frame(tbl[i].d, tbl[i].stop, 1'b0);
         bus_rd(A_STAT, d);
         check($sformatf("tbl%0d_stat", i), d, tbl[i].exp_stat);
         bus_rd(A_DATA, d);
         check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
         bus_rd(A_STAT, d);
         check($sformatf("tbl%0d_stat2", i), d, tbl[i].exp_stat2);
      end

      // overrun: nine frames into an eight-deep FIFO
      for (int i = 0; i < 9; i++) frame(8'(i), 1'b1, 1'b0);
      rd_stat_chk("ovr_status");
      for (int i = 0; i < 8; i++) rd_data_chk($sformatf("ovr_data%0d", i));
      rd_stat_chk("ovr_cleared");

      // short low glitch is rejected
      @(posedge clock);
      #1 rx = 1'b0;
      repeat (HALF - 2) @(posedge clock);
      #1 rx = 1'b1;
      repeat (2 * CPB) @(posedge clock);
      rd_stat_chk("glitch_status");
      frame(8'h69, 1'b1, 1'b0);
      rd_data_chk("after_glitch_data");

      // reset mid-byte with the line held low
      frame(8'h11, 1'b1, 1'b0);
      @(posedge clock);
      #1 rx = 1'b0;
      repeat (3 * CPB) @(posedge clock);
      do_reset(1'b0);
      repeat (12 * CPB) @(posedge clock);
      rd_stat_chk("lowreset_status");
      #1 check("lowreset_irq", {7'b0, rx_irq}, 8'h00);
      rx = 1'b1;
      repeat (CPB) @(posedge clock);
      frame(8'h42, 1'b1, 1'b0);
      rd_stat_chk("rearm_status");
      rd_data_chk("rearm_data");

      push_pop_same_edge(3, 8'hC3);
      push_pop_same_edge(DEPTH, 8'h99);

`ifdef UART_RX_PARITY_EN
      frame(8'h81, 1'b1, 1'b1);
      rd_stat_chk("perr_status");
      rd_data_chk("perr_data");
      rd_stat_chk("perr_cleared");
`endif

      // random frames with interleaved reads
      for (int k = 0; k < 25; k++) begin
         d  = 8'($urandom);
         st = $urandom_range(0, 9) != 0;
         pb = PEN && ($urandom_range(0, 5) == 0);
         frame(d, st, pb);
         if ($urandom_range(0, 2) == 0) begin
            nr = $urandom_range(0, 3);
            for (int j = 0; j < nr; j++) begin
               if ($urandom_range(0, 1) == 0) rd_stat_chk("rand_status");
               else rd_data_chk("rand_data");
            end
         end
      end
      rd_stat_chk("rand_final_status");
      while (mq.size() != 0) rd_data_chk("rand_drain");
      rd_data_chk("rand_empty");
      rd_stat_chk("rand_end_status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
